// File: rtl/sp_fifo_pkg.sv
// sp_fifo_pkg: shared constants and grant type for the
// single-port RAM FIFO controller.
package sp_fifo_pkg;

   localparam int WIDTH_D = 16;
   localparam int DEPTH_D = 512;
   localparam int AW_D    = 9;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_RD   = 2'd1,
      GNT_WR   = 2'd2
   } gnt_t;

endpackage

// File: rtl/sp_fifo_prefetch_buf.sv
// sp_fifo_prefetch_buf: 2-entry in-order buffer, append and pop
// in the same cycle. Ports: push/push_data, pop, head, count.
module sp_fifo_prefetch_buf #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] e0;
   logic [WIDTH-1:0] e1;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign head    = e0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else begin
         unique case ({do_push, do_pop})
            2'b11: begin
               if (count == 2'd1) begin
                  e0 <= push_data;
               end else begin
                  e0 <= e1;
                  e1 <= push_data;
               end
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b10: begin
               if (count == 2'd0) e0 <= push_data;
               else               e1 <= push_data;
               count <= count + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl: valid/ready FIFO over one single-port RAM.
// Ports: in_*/out_* streams, level, mem_* macro pins.
// Optional SP_FIFO_BYPASS_EN: wbuf -> pf when RAM is empty.
module sp_ram_fifo_ctrl
   import sp_fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_D,
   parameter int DEPTH = DEPTH_D,
   parameter int AW    = AW_D
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW+1:0]    level,
   output logic             mem_en,
   output logic             mem_wmode,
   output logic [AW-1:0]    mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam int          LW       = AW + 2;

   logic             wbuf_vld;
   logic [WIDTH-1:0] wbuf_data;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      ram_cnt;
   logic             rd_inflight;
   logic             prio;

   logic [1:0]       pf_cnt;
   logic [WIDTH-1:0] pf_head;
   logic             pf_push;
   logic [WIDTH-1:0] pf_din;

   logic             pop;
   logic             push;
   logic [2:0]       pf_occ;
   logic             pf_room;
   logic             wr_req;
   logic             rd_req;
   logic             byp;
   logic             conflict;
   gnt_t             gnt;
   logic             wr_go;
   logic             rd_go;

   assign out_valid = (pf_cnt != 2'd0);
   assign out_data  = pf_head;
   assign pop       = out_valid && out_ready;

   // Slots in pf that are taken or promised, after this pop.
   assign pf_occ  = {1'b0, pf_cnt} + {2'b0, rd_inflight};
   assign pf_room = (pf_occ - {2'b0, pop}) < 3'd2;

`ifdef SP_FIFO_BYPASS_EN
   assign byp = wbuf_vld && (ram_cnt == '0) &&
                !rd_inflight && pf_room;
`else
   assign byp = 1'b0;
`endif

   assign wr_req   = wbuf_vld && (ram_cnt < FULL_CNT) && !byp;
   assign rd_req   = (ram_cnt != '0) && pf_room;
   assign conflict = wr_req && rd_req;

   always_comb begin
      gnt = GNT_NONE;
      unique case ({wr_req, rd_req})
         2'b11:   gnt = prio ? GNT_WR : GNT_RD;
         2'b10:   gnt = GNT_WR;
         2'b01:   gnt = GNT_RD;
         default: gnt = GNT_NONE;
      endcase
   end

   assign wr_go = (gnt == GNT_WR);
   assign rd_go = (gnt == GNT_RD);

   assign mem_en    = wr_go || rd_go;
   assign mem_wmode = wr_go;
   assign mem_addr  = wr_go ? wr_ptr :
                      rd_go ? rd_ptr : '0;
   assign mem_wdata = wr_go ? wbuf_data : '0;

   assign in_ready = !wbuf_vld || wr_go || byp;
   assign push     = in_valid && in_ready;

   assign level = LW'(wbuf_vld) + LW'(ram_cnt) +
                  LW'(rd_inflight) + LW'(pf_cnt);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wbuf_vld  <= 1'b0;
         wbuf_data <= '0;
      end else if (push) begin
         wbuf_vld  <= 1'b1;
         wbuf_data <= in_data;
      end else if (wr_go || byp) begin
         wbuf_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ram_cnt     <= '0;
         rd_inflight <= 1'b0;
         prio        <= 1'b0;
      end else begin
         if (wr_go) wr_ptr <= wr_ptr + 1'b1;
         if (rd_go) rd_ptr <= rd_ptr + 1'b1;
         if (wr_go)      ram_cnt <= ram_cnt + 1'b1;
         else if (rd_go) ram_cnt <= ram_cnt - 1'b1;
         rd_inflight <= rd_go;
         if (conflict) prio <= ~prio;
      end
   end

   // Read data lands the cycle after the grant; bypass only
   // happens with no read in flight, so the sources never collide.
   assign pf_push = rd_inflight || byp;
   assign pf_din  = rd_inflight ? mem_rdata : wbuf_data;

   sp_fifo_prefetch_buf #(
      .WIDTH (WIDTH)
   ) u_pf (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (pf_push),
      .push_data (pf_din),
      .pop       (pop),
      .head      (pf_head),
      .count     (pf_cnt)
   );

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// tb_sp_ram_fifo_ctrl: directed bench for sp_ram_fifo_ctrl
// with a behavioural 512x16 single-port RAM model.
module tb_sp_ram_fifo_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [10:0] level;
   logic        mem_en;
   logic        mem_wmode;
   logic [8:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   logic [15:0] ram [512];
   logic [15:0] ram_q = 16'h0;
   logic        garbage = 1'b0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_wmode) ram[mem_addr] <= mem_wdata;
         else           ram_q <= ram[mem_addr];
      end
   end

   assign mem_rdata = garbage ? 16'hDEAD : ram_q;

   sp_ram_fifo_ctrl dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .mem_en    (mem_en),
      .mem_wmode (mem_wmode),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   typedef struct {
      logic        iv;
      logic [15:0] id;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic        e_en;
      logic        e_wm;
      logic [8:0]  e_addr;
      logic [15:0] e_wd;
      logic [10:0] e_lvl;
      logic [15:0] e_od;
   } vec_t;

   vec_t        tv [9];
   logic [15:0] words [1500];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   task automatic pop_one(input string nm,
                          input logic [15:0] exp);
      bit got = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clock);
         if (out_valid) begin
            got = 1;
            chk(nm, 32'(out_data), 32'(exp));
         end
      end
      if (!got) chk({nm, "_timeout"}, 0, 1);
      @(posedge clock);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      int acc;
      int cyc;
      int en_cnt;
      bit seen;

      tv[0] = '{1,16'h1111,0, 1,0,0,0,9'd0,16'h0000,11'd0,16'h0};
      tv[1] = '{1,16'h1112,0, 1,0,1,1,9'd0,16'h1111,11'd1,16'h0};
      tv[2] = '{1,16'h1113,0, 0,0,1,0,9'd0,16'h0000,11'd2,16'h0};
      tv[3] = '{1,16'h1113,0, 1,0,1,1,9'd1,16'h1112,11'd2,16'h0};
      tv[4] = '{1,16'h1114,0, 1,1,1,1,9'd2,16'h1113,11'd3,16'h1111};
      tv[5] = '{1,16'h1115,0, 0,1,1,0,9'd1,16'h0000,11'd4,16'h1111};
      tv[6] = '{1,16'h1115,0, 1,1,1,1,9'd3,16'h1114,11'd4,16'h1111};
      tv[7] = '{0,16'h0000,0, 1,1,1,1,9'd4,16'h1115,11'd5,16'h1111};
      tv[8] = '{0,16'h0000,0, 1,1,0,0,9'd0,16'h0000,11'd5,16'h1111};
      for (int i = 0; i < 1500; i++) words[i] = 16'($urandom);

      // Reset values, checked while reset is held.
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      out_ready = 1'b0;
      @(negedge clock);
      chk("rst_in_ready",  32'(in_ready),  1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data),  0);
      chk("rst_level",     32'(level),     0);
      chk("rst_mem_en",    32'(mem_en),    0);
      chk("rst_mem_wmode", 32'(mem_wmode), 0);
      chk("rst_mem_addr",  32'(mem_addr),  0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("idle_mem_en", 32'(mem_en), 0);
         chk("idle_level",  32'(level),  0);
      end

`ifndef SP_FIFO_BYPASS_EN
      // Cycle-by-cycle push of 0x1111..0x1115 with out_ready low.
      for (int i = 0; i < 9; i++) begin
         @(posedge clock);
         #1;
         in_valid  = tv[i].iv;
         in_data   = tv[i].id;
         out_ready = tv[i].ordy;
         @(negedge clock);
         chk($sformatf("v%0d_in_ready", i),
             32'(in_ready), 32'(tv[i].e_ir));
         chk($sformatf("v%0d_out_valid", i),
             32'(out_valid), 32'(tv[i].e_ov));
         chk($sformatf("v%0d_mem_en", i),
             32'(mem_en), 32'(tv[i].e_en));
         chk($sformatf("v%0d_mem_wmode", i),
             32'(mem_wmode), 32'(tv[i].e_wm));
         chk($sformatf("v%0d_mem_addr", i),
             32'(mem_addr), 32'(tv[i].e_addr));
         chk($sformatf("v%0d_mem_wdata", i),
             32'(mem_wdata), 32'(tv[i].e_wd));
         chk($sformatf("v%0d_level", i),
             32'(level), 32'(tv[i].e_lvl));
         if (tv[i].e_ov)
            chk($sformatf("v%0d_out_data", i),
                32'(out_data), 32'(tv[i].e_od));
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < 5; i++)
         pop_one($sformatf("seq_pop%0d", i), 16'(16'h1111 + i));
      @(negedge clock);
      chk("seq_level_empty", 32'(level), 0);
`endif

      // Single-word latency into an empty FIFO.
      do_reset();
      @(posedge clock);
      #1;
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      @(negedge clock);
      chk("lat_in_ready", 32'(in_ready), 1);
      @(posedge clock);
      #1 in_valid = 1'b0;
      cyc = 1;
      en_cnt = 0;
      seen = 0;
      while (cyc < 20 && !seen) begin
         @(negedge clock);
         if (out_valid) seen = 1;
         else begin
            if (mem_en) en_cnt++;
            @(posedge clock);
            #1 cyc++;
         end
      end
`ifdef SP_FIFO_BYPASS_EN
      chk("lat_cycles", cyc, 2);
      chk("lat_mem_en_count", en_cnt, 0);
`else
      chk("lat_cycles", cyc, 4);
      chk("lat_mem_en_count", en_cnt, 2);
`endif
      chk("lat_out_data", 32'(out_data), 32'h0000BEEF);

      // Fill to DEPTH+3 with out_ready low.
      do_reset();
      @(posedge clock);
      #1;
      acc = 0;
      in_valid = 1'b1;
      in_data  = 16'd0;
      for (int k = 0; k < 2000 && acc < 515; k++) begin
         @(negedge clock);
         if (in_ready) acc++;
         @(posedge clock);
         #1 in_data = 16'(acc);
      end
      chk("full_accepted", acc, 515);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("full_level", 32'(level), 515);
         chk("full_in_ready", 32'(in_ready), 0);
         @(posedge clock);
         #1;
      end
      @(negedge clock);
      chk("full_head", 32'(out_data), 0);
      out_ready = 1'b1;
      @(posedge clock);
      #1 out_ready = 1'b0;
      seen = 0;
      for (int k = 0; k < 5 && !seen; k++) begin
         @(negedge clock);
         if (in_ready) seen = 1;
         else begin
            @(posedge clock);
            #1;
         end
      end
      chk("full_in_ready_back", seen, 1);
      @(posedge clock);
      #1 in_valid = 1'b0;

      // Concurrent streaming of 1500 words.
      do_reset();
      @(posedge clock);
      #1;
      begin
         int pushed = 0;
         int popped = 0;
         int bad = 0;
         int wraps = 0;
         int waddr = 0;
         int addr_bad = 0;
         int in_st = 0;
         int out_st = 0;
         int in_max = 0;
         int out_max = 0;
         bit a;
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = words[0];
         for (int k = 0; k < 10000 && popped < 1500; k++) begin
            @(negedge clock);
            a = in_valid && in_ready;
            if (mem_en && mem_wmode) begin
               if (int'(mem_addr) != waddr) addr_bad++;
               if (waddr == 511) begin
                  waddr = 0;
                  wraps++;
               end else waddr++;
            end
            if (in_valid && popped >= 10) begin
               in_st = in_ready ? 0 : in_st + 1;
               out_st = out_valid ? 0 : out_st + 1;
               if (in_st > in_max) in_max = in_st;
               if (out_st > out_max) out_max = out_st;
            end
            if (out_valid) begin
               if (out_data !== words[popped]) bad++;
               popped++;
            end
            @(posedge clock);
            #1;
            if (a) begin
               pushed++;
               if (pushed < 1500) in_data = words[pushed];
               else in_valid = 1'b0;
            end
         end
         out_ready = 1'b0;
         chk("stream_popped", popped, 1500);
         chk("stream_order_errors", bad, 0);
         chk("stream_waddr_errors", addr_bad, 0);
         chk("stream_wraps", wraps, 2);
         chk("stream_in_stall_max", in_max, 1);
         chk("stream_out_stall_max", out_max, 1);
         @(negedge clock);
         chk("stream_level_end", 32'(level), 0);
      end

      // Reset with level 300 and a read in flight.
      do_reset();
      @(posedge clock);
      #1;
      in_valid = 1'b1;
      acc = 0;
      for (int k = 0; k < 1000 && level < 11'd300; k++) begin
         in_data = 16'(16'h4000 + k);
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      chk("mid_level_reached", 32'(level >= 11'd300), 1);
      out_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clock);
         if (mem_en && !mem_wmode) seen = 1;
         else begin
            @(posedge clock);
            #1;
         end
      end
      chk("mid_read_seen", seen, 1);
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      garbage = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      chk("mid_post_level", 32'(level), 0);
      chk("mid_post_out_valid", 32'(out_valid), 0);
      @(posedge clock);
      #1 garbage = 1'b0;
      @(negedge clock);
      chk("mid_post2_out_valid", 32'(out_valid), 0);
      chk("mid_post2_level", 32'(level), 0);
      @(posedge clock);
      #1;
      in_valid = 1'b1;
      in_data  = 16'h00A5;
      @(posedge clock);
      #1 in_valid = 1'b0;
      pop_one("mid_first_pop", 16'h00A5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=done");
      $fatal(1, "timeout");
   end

endmodule
